// File: rtl/lcd_sequencer_if.sv
// ---------------------------------------------------------------------------
// lcd_sequencer_if
// Byte request channel into the LCD sequencer (valid/ready handshake).
//   req_valid : requester has a byte to send
//   req_rs    : 0 = instruction, 1 = data
//   req_data  : byte to write
//   req_ready : sequencer accepts a request this cycle
// The requester holds req_valid/req_rs/req_data stable until the handshake.
// ---------------------------------------------------------------------------
interface lcd_sequencer_if;
   logic       req_valid;
   logic       req_rs;
   logic [7:0] req_data;
   logic       req_ready;

   modport master (
      output req_valid,
      output req_rs,
      output req_data,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_rs,
      input  req_data,
      output req_ready
   );
endinterface

// File: rtl/lcd_sequencer.sv
// ---------------------------------------------------------------------------
// lcd_sequencer
// Timing controller for an HD44780-style character LCD (8-bit, write-only).
// After reset it waits out the power-up delay, issues the fixed init command
// sequence (0x38, 0x0C, 0x01, 0x06) and then accepts one command/data byte
// at a time. Each byte gets setup time, an EN pulse, hold time and the
// post-command busy wait (long wait for clear/home).
//
// Ports:
//   clk       : system clock, all logic on posedge
//   reset     : synchronous active-high reset
//   req       : request channel (slave side of lcd_sequencer_if)
//   init_done : init sequence finished, held until next reset
//   busy      : high in every state except IDLE
//   rw        : constant 0 (write only)
//   rs        : LCD register select (registered)
//   en        : LCD enable (registered)
//   display   : LCD data bus (registered)
// ---------------------------------------------------------------------------
module lcd_sequencer #(
   parameter int CNT_W          = 20,
   parameter int POWERUP_CYC    = 750000,
   parameter int SETUP_CYC      = 2,
   parameter int EN_CYC         = 25,
   parameter int HOLD_CYC       = 2,
   parameter int SHORT_WAIT_CYC = 2500,
   parameter int LONG_WAIT_CYC  = 82000
) (
   input  logic                clk,
   input  logic                reset,
   lcd_sequencer_if.slave      req,
   output logic                init_done,
   output logic                busy,
   output logic                rw,
   output logic                rs,
   output logic                en,
   output logic [7:0]          display
);

   // Counter reload values: a phase of N cycles loads N-1 and exits at 0.
   localparam logic [CNT_W-1:0] POWERUP_LOAD = CNT_W'(POWERUP_CYC - 1);
   localparam logic [CNT_W-1:0] SETUP_LOAD   = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] EN_LOAD      = CNT_W'(EN_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] SHORT_LOAD   = CNT_W'(SHORT_WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] LONG_LOAD    = CNT_W'(LONG_WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);

   typedef enum logic [2:0] {
      ST_POWERUP = 3'd0,
      ST_INIT    = 3'd1,
      ST_IDLE    = 3'd2,
      ST_SETUP   = 3'd3,
      ST_PULSE   = 3'd4,
      ST_HOLD    = 3'd5,
      ST_WAIT    = 3'd6
   } state_t;

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [1:0]       init_idx_r;
   logic             rs_r;
   logic             en_r;
   logic [7:0]       display_r;
   logic             init_done_r;
   logic             req_ready_r;
   logic             busy_r;
   logic             cnt_zero_s;

   // Fixed power-up command table: function set, display on, clear, entry mode.
   function automatic logic [7:0] init_rom(input logic [1:0] idx);
      logic [7:0] val;
      case (idx)
         2'd0:    val = 8'h38;
         2'd1:    val = 8'h0C;
         2'd2:    val = 8'h01;
         2'd3:    val = 8'h06;
         default: val = 8'h00;
      endcase
      return val;
   endfunction

   // Clear (0x01) and home (0x02/0x03) need the long execution wait.
   function automatic logic is_long_cmd(input logic cmd_rs, input logic [7:0] cmd);
      return (cmd_rs == 1'b0) && (cmd[7:2] == 6'd0) && (cmd != 8'h00);
   endfunction

   assign cnt_zero_s = (cnt_r == CNT_ZERO);

   // Sequencer FSM: phase timing, LCD pins and handshake flags all registered here.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_POWERUP;
         cnt_r       <= POWERUP_LOAD;
         init_idx_r  <= 2'd0;
         rs_r        <= 1'b0;
         en_r        <= 1'b0;
         display_r   <= 8'h00;
         init_done_r <= 1'b0;
         req_ready_r <= 1'b0;
         busy_r      <= 1'b1;
      end else begin
         case (state_r)
            ST_POWERUP: begin
               if (cnt_zero_s) begin
                  state_r <= ST_INIT;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end

            ST_INIT: begin
               rs_r      <= 1'b0;
               display_r <= init_rom(init_idx_r);
               cnt_r     <= SETUP_LOAD;
               state_r   <= ST_SETUP;
            end

            // req_ready_r is only ever set together with entering IDLE after init.
            ST_IDLE: begin
               if (req.req_valid && req_ready_r) begin
                  rs_r        <= req.req_rs;
                  display_r   <= req.req_data;
                  cnt_r       <= SETUP_LOAD;
                  state_r     <= ST_SETUP;
                  req_ready_r <= 1'b0;
                  busy_r      <= 1'b1;
               end
            end

            ST_SETUP: begin
               if (cnt_zero_s) begin
                  en_r    <= 1'b1;
                  cnt_r   <= EN_LOAD;
                  state_r <= ST_PULSE;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end

            ST_PULSE: begin
               if (cnt_zero_s) begin
                  en_r    <= 1'b0;
                  cnt_r   <= HOLD_LOAD;
                  state_r <= ST_HOLD;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end

            // rs/display are still the latched byte here, so they select the wait.
            ST_HOLD: begin
               if (cnt_zero_s) begin
                  cnt_r   <= is_long_cmd(rs_r, display_r) ? LONG_LOAD : SHORT_LOAD;
                  state_r <= ST_WAIT;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end

            ST_WAIT: begin
               if (cnt_zero_s) begin
                  if (!init_done_r && (init_idx_r != 2'd3)) begin
                     init_idx_r <= init_idx_r + 2'd1;
                     state_r    <= ST_INIT;
                  end else begin
                     init_done_r <= 1'b1;
                     req_ready_r <= 1'b1;
                     busy_r      <= 1'b0;
                     state_r     <= ST_IDLE;
                  end
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end

            // Unreachable encoding: recover by restarting the whole power-up.
            default: begin
               state_r     <= ST_POWERUP;
               cnt_r       <= POWERUP_LOAD;
               init_idx_r  <= 2'd0;
               rs_r        <= 1'b0;
               en_r        <= 1'b0;
               display_r   <= 8'h00;
               init_done_r <= 1'b0;
               req_ready_r <= 1'b0;
               busy_r      <= 1'b1;
            end
         endcase
      end
   end

   assign req.req_ready = req_ready_r;
   assign init_done     = init_done_r;
   assign busy          = busy_r;
   assign rw            = 1'b0;
   assign rs            = rs_r;
   assign en            = en_r;
   assign display       = display_r;

endmodule

// File: tb/tb_lcd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lcd_sequencer
// Directed bench for lcd_sequencer with shortened timing
// (POWERUP 10, SETUP 2, EN 3, HOLD 2, SHORT 4, LONG 8).
// A monitor records every en pulse (start cycle, width, rs, display);
// expected cycle positions are hand-derived from the timing parameters.
// ---------------------------------------------------------------------------
module tb_lcd_sequencer;

   logic       clk;
   logic       reset;
   logic       init_done;
   logic       busy;
   logic       rw;
   logic       rs;
   logic       en;
   logic [7:0] display;

   lcd_sequencer_if req_if ();

   lcd_sequencer #(
      .CNT_W          (20),
      .POWERUP_CYC    (10),
      .SETUP_CYC      (2),
      .EN_CYC         (3),
      .HOLD_CYC       (2),
      .SHORT_WAIT_CYC (4),
      .LONG_WAIT_CYC  (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req_if),
      .init_done (init_done),
      .busy      (busy),
      .rw        (rw),
      .rs        (rs),
      .en        (en),
      .display   (display)
   );

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;

   // en pulse log filled by the monitor
   int       p_start[$];
   int       p_width[$];
   int       p_rs[$];
   int       p_data[$];
   int       glitch_cnt = 0;
   logic     en_prev = 1'b0;
   int       cur_start = 0;
   logic     cur_rs = 1'b0;
   logic [7:0] cur_data = 8'h00;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle index: number of posedges seen so far.
   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor, sampling 1 time unit after each posedge.
   always begin
      @(posedge clk);
      #1;
      if (en === 1'b1 && en_prev !== 1'b1) begin
         cur_start = cyc;
         cur_rs    = rs;
         cur_data  = display;
      end
      if (en === 1'b1 && en_prev === 1'b1 && (display !== cur_data || rs !== cur_rs))
         glitch_cnt++;
      if (en !== 1'b1 && en_prev === 1'b1) begin
         p_start.push_back(cur_start);
         p_width.push_back(cyc - cur_start);
         p_rs.push_back(int'(cur_rs));
         p_data.push_back(int'(cur_data));
      end
      en_prev = en;
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(output int t_rdy);
      int n;
      n = 0;
      while (req_if.req_ready !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      check_eq("ready_reached", {31'd0, req_if.req_ready}, 32'd1);
      t_rdy = cyc;
   endtask

   // Called at a sample where req_ready is 1; returns the handshake cycle.
   task automatic send(input logic s_rs, input logic [7:0] s_data, output int t_hs);
      req_if.req_rs    = s_rs;
      req_if.req_data  = s_data;
      req_if.req_valid = 1'b1;
      tick();
      t_hs = cyc;
      req_if.req_valid = 1'b0;
   endtask

   task automatic expect_pulse(input string tag, input logic e_rs, input logic [7:0] e_data,
                               input int e_start);
      if (p_start.size() == 0) begin
         check_eq({tag, "_present"}, 32'd0, 32'd1);
      end else begin
         check_eq({tag, "_start"}, p_start.pop_front(), e_start);
         check_eq({tag, "_width"}, p_width.pop_front(), 32'd3);
         check_eq({tag, "_rs"},    p_rs.pop_front(),    {31'd0, e_rs});
         check_eq({tag, "_data"},  p_data.pop_front(),  {24'd0, e_data});
      end
   endtask

   initial begin
      int r0, t, t_rdy, t1, t2, t3, tr;
      reset            = 1'b1;
      req_if.req_valid = 1'b0;
      req_if.req_rs    = 1'b0;
      req_if.req_data  = 8'h00;

      // ---- reset state ----
      tick(); tick(); tick();
      check_eq("rst_ready",     {31'd0, req_if.req_ready}, 32'd0);
      check_eq("rst_busy",      {31'd0, busy},      32'd1);
      check_eq("rst_en",        {31'd0, en},        32'd0);
      check_eq("rst_rs",        {31'd0, rs},        32'd0);
      check_eq("rst_display",   {24'd0, display},   32'h00);
      check_eq("rst_init_done", {31'd0, init_done}, 32'd0);
      check_eq("rst_rw",        {31'd0, rw},        32'd0);
      r0    = cyc;
      reset = 1'b0;

      // ---- test 1: power-up and init ----
      wait_ready(t_rdy);
      check_eq("init_done_time", t_rdy - r0, 32'd62);
      check_eq("init_done_flag", {31'd0, init_done}, 32'd1);
      check_eq("init_busy_low",  {31'd0, busy},      32'd0);
      expect_pulse("init0", 1'b0, 8'h38, r0 + 13);
      expect_pulse("init1", 1'b0, 8'h0C, r0 + 25);
      expect_pulse("init2", 1'b0, 8'h01, r0 + 37);
      expect_pulse("init3", 1'b0, 8'h06, r0 + 53);

      // ---- test 2: data write ----
      send(1'b1, 8'h41, t);
      check_eq("wr_rs",      {31'd0, rs},    32'd1);
      check_eq("wr_display", {24'd0, display}, 32'h41);
      check_eq("wr_busy",    {31'd0, busy},  32'd1);
      check_eq("wr_ready",   {31'd0, req_if.req_ready}, 32'd0);
      tick();
      check_eq("wr_en_t1", {31'd0, en}, 32'd0);
      tick();
      check_eq("wr_en_t2", {31'd0, en}, 32'd1);
      wait_ready(t_rdy);
      check_eq("wr_ready_time", t_rdy - t, 32'd11);
      check_eq("wr_busy_end",   {31'd0, busy}, 32'd0);
      expect_pulse("wr", 1'b1, 8'h41, t + 2);

      // ---- test 3: long vs short wait ----
      send(1'b0, 8'h01, t);
      wait_ready(t_rdy);
      check_eq("clr_wait", t_rdy - t, 32'd15);
      expect_pulse("clr", 1'b0, 8'h01, t + 2);
      send(1'b0, 8'h02, t);
      wait_ready(t_rdy);
      check_eq("home_wait", t_rdy - t, 32'd15);
      expect_pulse("home", 1'b0, 8'h02, t + 2);
      send(1'b1, 8'h01, t);
      wait_ready(t_rdy);
      check_eq("data01_wait", t_rdy - t, 32'd11);
      expect_pulse("data01", 1'b1, 8'h01, t + 2);

      // ---- test 4: back-to-back stream with req_valid held ----
      req_if.req_rs    = 1'b1;
      req_if.req_data  = 8'h48;
      req_if.req_valid = 1'b1;
      tick();
      t1 = cyc;
      check_eq("b2b_rdy_drop1", {31'd0, req_if.req_ready}, 32'd0);
      req_if.req_data = 8'h49;
      wait_ready(tr);
      check_eq("b2b_rdy_time2", tr - t1, 32'd11);
      tick();
      t2 = cyc;
      check_eq("b2b_rdy_drop2", {31'd0, req_if.req_ready}, 32'd0);
      check_eq("b2b_disp2",     {24'd0, display}, 32'h49);
      req_if.req_data = 8'h21;
      wait_ready(tr);
      tick();
      t3 = cyc;
      check_eq("b2b_rdy_drop3", {31'd0, req_if.req_ready}, 32'd0);
      req_if.req_valid = 1'b0;
      check_eq("b2b_gap23", t3 - t2, 32'd12);
      wait_ready(t_rdy);
      check_eq("b2b_final_wait", t_rdy - t3, 32'd11);
      expect_pulse("b2b0", 1'b1, 8'h48, t1 + 2);
      expect_pulse("b2b1", 1'b1, 8'h49, t1 + 14);
      expect_pulse("b2b2", 1'b1, 8'h21, t1 + 26);

      // ---- test 5: request changes while busy are ignored ----
      send(1'b1, 8'h55, t);
      req_if.req_valid = 1'b1;
      req_if.req_rs    = 1'b0;
      req_if.req_data  = 8'hAA;
      tick(); tick();
      req_if.req_data = 8'h01;
      tick(); tick();
      req_if.req_valid = 1'b0;
      wait_ready(t_rdy);
      check_eq("hold_ready_time", t_rdy - t, 32'd11);
      tick(); tick(); tick();
      check_eq("hold_pulse_count", p_start.size(), 32'd1);
      check_eq("hold_display",     {24'd0, display}, 32'h55);
      check_eq("hold_rs",          {31'd0, rs},      32'd1);
      expect_pulse("hold", 1'b1, 8'h55, t + 2);

      // ---- test 6: reset in the middle of an en pulse ----
      send(1'b1, 8'h5A, t);
      tick(); tick(); tick();
      check_eq("mid_en_high", {31'd0, en}, 32'd1);
      reset = 1'b1;
      tick();
      check_eq("mid_rst_en",        {31'd0, en},        32'd0);
      check_eq("mid_rst_rs",        {31'd0, rs},        32'd0);
      check_eq("mid_rst_display",   {24'd0, display},   32'h00);
      check_eq("mid_rst_init_done", {31'd0, init_done}, 32'd0);
      check_eq("mid_rst_ready",     {31'd0, req_if.req_ready}, 32'd0);
      r0    = cyc;
      reset = 1'b0;
      tick();
      p_start.delete();
      p_width.delete();
      p_rs.delete();
      p_data.delete();
      begin
         int n;
         n = 0;
         while (p_start.size() == 0 && n < 100) begin
            tick();
            n++;
         end
      end
      expect_pulse("reinit0", 1'b0, 8'h38, r0 + 13);
      check_eq("reinit_not_done", {31'd0, init_done}, 32'd0);

      check_eq("display_stable_during_en", glitch_cnt, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
